// File: rtl/jt12_timer_regs.sv
// CPU-side register writer for the JT12 timer pair: decodes address/data bus
// cycles into timer registers 0x24-0x27, tracks write-busy and returns status.
module jt12_timer_regs #(
    parameter int BUSY_CYCLES = 32,
    parameter int BW          = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       cpu_cs_n,
    input  logic       cpu_wr_n,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    input  logic       flag_A,
    input  logic       flag_B,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic [1:0] ch3_mode,
    output logic       busy
);

    localparam logic [BW-1:0] BUSY_LOAD = BW'(BUSY_CYCLES);

    logic          access;
    logic          access_d;
    logic          accept;
    logic          addr_wr;
    logic          data_wr;
    logic          reg_wr;
    logic [7:0]    addr;
    logic          part2;
    logic [BW-1:0] busy_cnt;

    // A held strobe is accepted only on its first clk.
    assign access  = !cpu_cs_n && !cpu_wr_n;
    assign accept  = access && !access_d;
    assign addr_wr = accept && !cpu_addr[0];
    assign data_wr = accept &&  cpu_addr[0];
    assign reg_wr  = data_wr && !part2;
    assign busy    = busy_cnt != '0;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            access_d <= 1'b0;
            addr     <= 8'h00;
            part2    <= 1'b0;
        end else begin
            access_d <= access;
            if (addr_wr) begin
                addr  <= cpu_din;
                part2 <= cpu_addr[1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_A      <= '0;
            value_B      <= '0;
            load_A       <= 1'b0;
            load_B       <= 1'b0;
            enable_irq_A <= 1'b0;
            enable_irq_B <= 1'b0;
            ch3_mode     <= '0;
            clr_flag_A   <= 1'b0;
            clr_flag_B   <= 1'b0;
        end else begin
            // Clear strobes are rewritten every clk so they last exactly one cycle.
            clr_flag_A <= reg_wr && (addr == 8'h27) && cpu_din[4];
            clr_flag_B <= reg_wr && (addr == 8'h27) && cpu_din[5];
            if (reg_wr) begin
                case (addr)
                    8'h24: value_A[9:2] <= cpu_din;
                    8'h25: value_A[1:0] <= cpu_din[1:0];
                    8'h26: value_B      <= cpu_din;
                    8'h27: begin
                        ch3_mode     <= cpu_din[7:6];
                        enable_irq_B <= cpu_din[3];
                        enable_irq_A <= cpu_din[2];
                        load_B       <= cpu_din[1];
                        load_A       <= cpu_din[0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Any data write, decoded or not, restarts the busy window; reload beats decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (data_wr) begin
            busy_cnt <= BUSY_LOAD;
        end else if (clk_en && busy) begin
            busy_cnt <= busy_cnt - BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_dout <= 8'h00;
        end else begin
            cpu_dout <= {busy, 5'b0, flag_B, flag_A};
        end
    end

endmodule
